// File: rtl/regfile_write_arbiter.sv
// Two-requester write-back arbiter for the 32x32 register file: per-requester FIFOs,
// round-robin drain into a registered write port, plus a pending-write hazard mask.
module regfile_write_arbiter #(
    parameter int DEPTH = 2,
    parameter int DW    = 32,
    parameter int AW    = 5,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [AW-1:0]     a_addr,
    input  logic [DW-1:0]     a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [AW-1:0]     b_addr,
    input  logic [DW-1:0]     b_data,
    output logic              b_ready,
    output logic              we,
    output logic [AW-1:0]     write_addr,
    output logic [DW-1:0]     write_data,
    output logic [(2**AW)-1:0] pending,
    output logic [CW-1:0]     a_count,
    output logic [CW-1:0]     b_count
);

    logic [AW-1:0] addr_mem_p0 [2][DEPTH];
    logic [DW-1:0] data_mem_p0 [2][DEPTH];
    logic [PW-1:0] rd_ptr [2];
    logic [PW-1:0] wr_ptr [2];
    logic [CW-1:0] count  [2];

    logic [1:0]    in_vld;
    logic [AW-1:0] in_addr [2];
    logic [DW-1:0] in_data [2];
    logic [1:0]    rdy;
    logic [1:0]    not_empty;
    logic [1:0]    push;
    logic [1:0]    pop;
    logic          sel;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;
    logic          last_grant_b;

    logic          vld_p1;
    logic [AW-1:0] addr_p1;
    logic [DW-1:0] data_p1;

    logic [(2**AW)-1:0] pend;

    // An entry slot is live when its distance from the read pointer is below the occupancy.
    function automatic logic entry_live(input logic [PW-1:0] idx,
                                        input logic [PW-1:0] rd,
                                        input logic [CW-1:0] cnt);
        logic [PW-1:0] off;
        off = idx - rd;
        return {1'b0, off} < cnt;
    endfunction

    assign in_vld     = {b_valid, a_valid};
    assign in_addr[0] = a_addr;
    assign in_addr[1] = b_addr;
    assign in_data[0] = a_data;
    assign in_data[1] = b_data;

    always_comb begin
        rdy       = '0;
        not_empty = '0;
        push      = '0;
        for (int r = 0; r < 2; r++) begin
            rdy[r]       = (count[r] != CW'(DEPTH));
            not_empty[r] = (count[r] != '0);
            push[r]      = in_vld[r] && rdy[r];
        end
        pop[0] = not_empty[0] && (!not_empty[1] || last_grant_b);
        pop[1] = not_empty[1] && (!not_empty[0] || !last_grant_b);
        sel       = pop[1];
        head_addr = addr_mem_p0[sel][rd_ptr[sel]];
        head_data = data_mem_p0[sel][rd_ptr[sel]];
    end

    assign a_ready = rdy[0];
    assign b_ready = rdy[1];
    assign a_count = count[0];
    assign b_count = count[1];

    // ---- stage p0: FIFO control and storage ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < 2; r++) begin
                rd_ptr[r] <= '0;
                wr_ptr[r] <= '0;
                count[r]  <= '0;
            end
            last_grant_b <= 1'b1;
        end else begin
            for (int r = 0; r < 2; r++) begin
                if (push[r]) wr_ptr[r] <= wr_ptr[r] + PW'(1);
                if (pop[r])  rd_ptr[r] <= rd_ptr[r] + PW'(1);
                count[r] <= count[r] + CW'(push[r]) - CW'(pop[r]);
            end
            if (|pop) last_grant_b <= pop[1];
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < 2; r++) begin
            if (push[r]) begin
                addr_mem_p0[r][wr_ptr[r]] <= in_addr[r];
                data_mem_p0[r][wr_ptr[r]] <= in_data[r];
            end
        end
    end

    // ---- stage p1: registered write port; register 0 writes are consumed with we low ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
            data_p1 <= '0;
        end else if (|pop) begin
            vld_p1  <= (head_addr != '0);
            addr_p1 <= head_addr;
            data_p1 <= head_data;
        end else begin
            vld_p1  <= 1'b0;
        end
    end

    assign we         = vld_p1;
    assign write_addr = addr_p1;
    assign write_data = data_p1;

    always_comb begin
        pend = '0;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entry_live(PW'(i), rd_ptr[r], count[r])) pend[addr_mem_p0[r][i]] = 1'b1;
            end
        end
        if (vld_p1) pend[addr_p1] = 1'b1;
        pend[0] = 1'b0;
    end

    assign pending = pend;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: per-requester expected queues, pending-mask model,
// write log for ordering and throughput checks.
module tb_regfile_write_arbiter;

    logic        clk;
    logic        rst;
    logic        a_valid, b_valid;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready;
    logic        we;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [31:0] pending;
    logic [1:0]  a_count, b_count;

    regfile_write_arbiter #(.DEPTH(2), .DW(32), .AW(5)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .we(we), .write_addr(write_addr), .write_data(write_data),
        .pending(pending), .a_count(a_count), .b_count(b_count)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [36:0] exp_a[$];
    logic [36:0] exp_b[$];
    int          log_cyc[$];
    logic [4:0]  log_addr[$];
    logic [31:0] log_data[$];

    logic [36:0] mon_got, mon_want;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] model_pending();
        logic [31:0] m;
        m = '0;
        foreach (exp_a[i]) m[exp_a[i][36:32]] = 1'b1;
        foreach (exp_b[i]) m[exp_b[i][36:32]] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    // Monitor: compares every write against the head of the matching requester queue.
    always @(negedge clk) begin
        if (rst) begin
            chk("pending", pending, model_pending());
            chk("a_ready", a_ready, a_count != 2'd2);
            chk("b_ready", b_ready, b_count != 2'd2);
            if (we) begin
                mon_got  = {write_addr, write_data};
                mon_want = '0;
                if (exp_a.size() > 0 && exp_a[0] == mon_got) begin
                    mon_want = exp_a.pop_front();
                end else if (exp_b.size() > 0 && exp_b[0] == mon_got) begin
                    mon_want = exp_b.pop_front();
                end else if (exp_a.size() > 0) begin
                    mon_want = exp_a[0];
                end else if (exp_b.size() > 0) begin
                    mon_want = exp_b[0];
                end
                chk("wr_entry", mon_got, mon_want);
                log_cyc.push_back(cyc);
                log_addr.push_back(write_addr);
                log_data.push_back(write_data);
            end
        end
    end

    task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                         output logic acc_a, output logic acc_b);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        acc_a = av && a_ready;
        acc_b = bv && b_ready;
        @(posedge clk);
        if (acc_a && aa != 5'd0) exp_a.push_back({aa, ad});
        if (acc_b && ba != 5'd0) exp_b.push_back({ba, bd});
        #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while (n < max_cyc && (a_count != 0 || b_count != 0 || we)) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", n < max_cyc, 1);
    endtask

    task automatic clear_log();
        log_cyc.delete();
        log_addr.delete();
        log_data.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic acc_a, acc_b;
        logic full_seen;
        int   ra, rb, first_push;
        logic [4:0] order [4];

        rst = 1'b0;
        a_valid = 1'b0; a_addr = '0; a_data = '0;
        b_valid = 1'b0; b_addr = '0; b_data = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", we, 0);
        chk("rst_waddr", write_addr, 0);
        chk("rst_wdata", write_data, 0);
        chk("rst_pending", pending, 0);
        chk("rst_a_count", a_count, 0);
        chk("rst_b_count", b_count, 0);
        chk("rst_a_ready", a_ready, 1);
        chk("rst_b_ready", b_ready, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset mid-stream with entries queued and a write on the port.
        drive(1, 5'd7, 32'h1111_0007, 1, 5'd9, 32'h1111_0009, acc_a, acc_b);
        drive(1, 5'd8, 32'h1111_0008, 1, 5'd10, 32'h1111_000A, acc_a, acc_b);
        chk("pre_rst_we", we, 1);
        chk("pre_rst_b_count", b_count, 2);
        rst = 1'b0;
        exp_a.delete();
        exp_b.delete();
        #1;
        chk("mid_rst_we", we, 0);
        chk("mid_rst_waddr", write_addr, 0);
        chk("mid_rst_a_count", a_count, 0);
        chk("mid_rst_b_count", b_count, 0);
        chk("mid_rst_pending", pending, 0);
        chk("mid_rst_a_ready", a_ready, 1);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Contention right after reset: A wins first.
        clear_log();
        drive(1, 5'd1, 32'h2000_0001, 1, 5'd3, 32'h2000_0003, acc_a, acc_b);
        drive(1, 5'd2, 32'h2000_0002, 1, 5'd4, 32'h2000_0004, acc_a, acc_b);
        wait_idle(20);
        order[0] = 5'd1; order[1] = 5'd3; order[2] = 5'd2; order[3] = 5'd4;
        chk("cont_count", log_addr.size(), 4);
        if (log_addr.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("cont_order", log_addr[k], order[k]);
                chk("cont_cycle", log_cyc[k], log_cyc[0] + k);
            end
        end

        // Single write latency and pending window.
        drive(1, 5'd5, 32'hDEAD_BEEF, 0, 5'd0, 32'h0, acc_a, acc_b);
        chk("single_a_count", a_count, 1);
        chk("single_pend_e0", pending[5], 1);
        chk("single_we_e0", we, 0);
        @(posedge clk);
        #1;
        chk("single_we_e1", we, 1);
        chk("single_waddr", write_addr, 5);
        chk("single_wdata", write_data, 32'hDEAD_BEEF);
        chk("single_pend_e1", pending[5], 1);
        @(posedge clk);
        #1;
        chk("single_we_e2", we, 0);
        chk("single_pend_e2", pending[5], 0);
        chk("single_hold_wdata", write_data, 32'hDEAD_BEEF);

        // Register 0 write is consumed silently.
        clear_log();
        drive(0, 5'd0, 32'h0, 1, 5'd0, 32'h1234_5678, acc_a, acc_b);
        chk("zero_b_count_e0", b_count, 1);
        chk("zero_pending_e0", pending, 0);
        @(posedge clk);
        #1;
        chk("zero_b_count_e1", b_count, 0);
        chk("zero_we_e1", we, 0);
        chk("zero_pending_e1", pending, 0);
        @(posedge clk);
        #1;
        chk("zero_no_write", log_addr.size(), 0);

        // Backpressure: both requesters hold valid until all 8 entries are accepted.
        clear_log();
        ra = 4;
        rb = 4;
        full_seen = 1'b0;
        for (int n = 0; n < 60 && (ra > 0 || rb > 0); n++) begin
            if (b_count == 2'd2 && !b_ready) full_seen = 1'b1;
            drive(ra > 0, 5'(10 + 4 - ra), 32'hB0A0_0000 + 32'(4 - ra),
                  rb > 0, 5'(20 + 4 - rb), 32'hB0B0_0000 + 32'(4 - rb), acc_a, acc_b);
            if (acc_a) ra--;
            if (acc_b) rb--;
        end
        chk("bp_all_accepted", ra + rb, 0);
        chk("bp_b_full_seen", full_seen, 1);
        wait_idle(40);
        chk("bp_write_count", log_addr.size(), 8);

        // Wrap-around: 10 back-to-back A pushes, one write per cycle.
        clear_log();
        first_push = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1, 5'(1 + i), 32'hC000_0000 + 32'(i), 0, 5'd0, 32'h0, acc_a, acc_b);
            chk("wrap_accept", acc_a, 1);
            if (i == 0) first_push = cyc;
        end
        wait_idle(20);
        chk("wrap_count", log_addr.size(), 10);
        if (log_addr.size() == 10) begin
            for (int k = 0; k < 10; k++) begin
                chk("wrap_cycle", log_cyc[k], first_push + 1 + k);
                chk("wrap_data", log_data[k], 32'hC000_0000 + 32'(k));
            end
        end

        chk("exp_a_left", exp_a.size(), 0);
        chk("exp_b_left", exp_b.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
